// File: rtl/param_updown_counter.sv
// Parameterised up/down counter with enable prescaler, synchronous load,
// wrap or saturate behaviour at the limits, a one-cycle terminal-count
// pulse and a sticky overflow/underflow flag.
module param_updown_counter #(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = '1,
    parameter int unsigned      PRESCALE = 1,
    parameter bit               SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             tc,
    output logic             ovf
);

    // Prescaler runs 0..PRESCALE-1; 16 bits covers the full legal range.
    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    logic [15:0]      presc_q, presc_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    logic             at_limit;
    logic             set_evt;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] load_clamped;

    // Step strobe: enabled cycle in which the prescaler is at its last value.
    always_comb begin
        tick = en && (presc_q == PRESC_LAST);
    end

    // Value the counter would take on a step, and whether the step hits a limit.
    always_comb begin
        at_limit = up ? (count_q == MAX_VAL) : (count_q == '0);
        step_val = count_q;
        if (up) begin
            if (count_q == MAX_VAL) begin
                step_val = SATURATE ? count_q : '0;
            end else begin
                step_val = count_q + 1'b1;
            end
        end else begin
            if (count_q == '0) begin
                step_val = SATURATE ? count_q : MAX_VAL;
            end else begin
                step_val = count_q - 1'b1;
            end
        end
        load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end

    // Next-state selection: rst > load > step > hold.
    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        set_evt = 1'b0;
        if (rst) begin
            presc_d = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (load) begin
            // Load swallows any coincident step; ovf only reacts to clr_ovf.
            presc_d = '0;
            count_d = load_clamped;
            if (clr_ovf) begin
                ovf_d = 1'b0;
            end
        end else begin
            if (en) begin
                presc_d = tick ? '0 : presc_q + 16'd1;
            end
            if (tick) begin
                count_d = step_val;
                set_evt = at_limit;
            end
            tc_d = set_evt;
            // A coinciding set event takes precedence over the clear.
            if (set_evt) begin
                ovf_d = 1'b1;
            end else if (clr_ovf) begin
                ovf_d = 1'b0;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        presc_q <= presc_d;
        count_q <= count_d;
        tc_q    <= tc_d;
        ovf_q   <= ovf_d;
    end

    // Registered outputs.
    always_comb begin
        q   = count_q;
        tc  = tc_q;
        ovf = ovf_q;
    end

endmodule

// File: tb/tb_param_updown_counter.sv
// Scoreboard bench: the driver pushes hand-computed expectations per cycle,
// the monitor pops one per clock and compares against the selected DUT.
module tb_param_updown_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0, en = 1'b0, up = 1'b0, load = 1'b0, clr_ovf = 1'b0;
    logic [3:0] load_val = '0;

    logic [2:0] q0;
    logic [3:0] q1, q2, q3;
    logic       tick0, tick1, tick2, tick3;
    logic       tc0, tc1, tc2, tc3;
    logic       ovf0, ovf1, ovf2, ovf3;

    int n_vec = 0;
    int n_miss = 0;

    typedef struct {
        int         id;
        logic [3:0] q;
        logic       tc;
        logic       ovf;
        logic       tick;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    // id 0: WIDTH=3, defaults
    param_updown_counter #(.WIDTH(3)) u0 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val[2:0]), .clr_ovf(clr_ovf),
        .q(q0), .tick(tick0), .tc(tc0), .ovf(ovf0));

    // id 1: WIDTH=4, MAX_VAL=9, wrap
    param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9)) u1 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .clr_ovf(clr_ovf),
        .q(q1), .tick(tick1), .tc(tc1), .ovf(ovf1));

    // id 2: WIDTH=4, MAX_VAL=9, saturate
    param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1)) u2 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .clr_ovf(clr_ovf),
        .q(q2), .tick(tick2), .tc(tc2), .ovf(ovf2));

    // id 3: WIDTH=4, PRESCALE=4
    param_updown_counter #(.WIDTH(4), .PRESCALE(4)) u3 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .clr_ovf(clr_ovf),
        .q(q3), .tick(tick3), .tc(tc3), .ovf(ovf3));

    // Drive one cycle of inputs at the falling edge and queue the expectation:
    // etick is tick before the edge, eq/etc/eovf are the outputs after it.
    task automatic drive(input int id, input logic r, input logic e, input logic u,
                         input logic l, input logic [3:0] lv, input logic c,
                         input logic [3:0] eq, input logic etc, input logic eovf,
                         input logic etick);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; up = u; load = l; load_val = lv; clr_ovf = c;
        x.id = id; x.q = eq; x.tc = etc; x.ovf = eovf; x.tick = etick;
        sb.push_back(x);
    endtask

    // Monitor: sample tick mid-low-phase, outputs just after the rising edge.
    initial begin
        logic [3:0] tk;
        logic [3:0] aq;
        logic       atc, aovf, atk;
        exp_t       x;
        forever begin
            @(negedge clk);
            #3;
            tk = {tick3, tick2, tick1, tick0};
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                case (x.id)
                    0:       begin aq = {1'b0, q0}; atc = tc0; aovf = ovf0; end
                    1:       begin aq = q1; atc = tc1; aovf = ovf1; end
                    2:       begin aq = q2; atc = tc2; aovf = ovf2; end
                    default: begin aq = q3; atc = tc3; aovf = ovf3; end
                endcase
                atk = tk[x.id];
                n_vec++;
                if ({aq, atc, aovf, atk} !== {x.q, x.tc, x.ovf, x.tick}) begin
                    n_miss++;
                    $display("FAIL vec%0d dut%0d: got q=%0d tc=%b ovf=%b tick=%b, want q=%0d tc=%b ovf=%b tick=%b",
                             n_vec, x.id, aq, atc, aovf, atk, x.q, x.tc, x.ovf, x.tick);
                end
            end
        end
    end

    initial begin
        // ---- dut0: WIDTH=3 wrap up count ----
        drive(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 7; k++) drive(0, 0, 1, 1, 0, 0, 0, 4'(k), 0, 0, 1);
        drive(0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 1);        // 7 -> 0
        drive(0, 0, 1, 1, 0, 0, 0, 1, 0, 1, 1);
        drive(0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0);        // hold

        // ---- dut1: WIDTH=4 MAX_VAL=9 wrap ----
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 1, 0, 0, 0, 0, 9, 1, 1, 1);        // 0 -> 9 underflow
        for (int k = 8; k >= 0; k--) drive(1, 0, 1, 0, 0, 0, 0, 4'(k), 0, 1, 1);
        drive(1, 0, 1, 0, 0, 0, 0, 9, 1, 1, 1);        // 0 -> 9 again
        drive(1, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0);        // clr_ovf
        drive(1, 0, 1, 1, 0, 0, 1, 0, 1, 1, 1);        // set beats clear
        drive(1, 1, 1, 0, 1, 5, 0, 0, 0, 0, 1);        // rst beats load
        drive(1, 0, 1, 1, 1, 13, 0, 9, 0, 0, 1);       // clamped load, step suppressed
        drive(1, 0, 1, 1, 0, 0, 0, 0, 1, 1, 1);        // 9 -> 0
        drive(1, 0, 0, 1, 1, 4, 0, 4, 0, 1, 0);        // load keeps ovf
        drive(1, 0, 1, 0, 0, 0, 0, 3, 0, 1, 1);

        // ---- dut2: saturate ----
        drive(2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 9; k++) drive(2, 0, 1, 1, 0, 0, 0, 4'(k), 0, 0, 1);
        for (int k = 0; k < 3; k++) drive(2, 0, 1, 1, 0, 0, 0, 9, 1, 1, 1);
        drive(2, 0, 1, 0, 0, 0, 0, 8, 0, 1, 1);
        drive(2, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        drive(2, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1);
        drive(2, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1);

        // ---- dut3: PRESCALE=4 ----
        drive(3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) drive(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(3, 0, 1, 1, 0, 0, 0, 1, 0, 0, 1);        // tick, up sampled here
        for (int k = 0; k < 3; k++) drive(3, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        drive(3, 0, 1, 1, 0, 0, 0, 2, 0, 0, 1);
        drive(3, 0, 0, 1, 0, 0, 0, 2, 0, 0, 0);        // en low x2
        drive(3, 0, 0, 1, 0, 0, 0, 2, 0, 0, 0);
        for (int k = 0; k < 3; k++) drive(3, 0, 1, 1, 0, 0, 0, 2, 0, 0, 0);
        drive(3, 0, 1, 1, 0, 0, 0, 3, 0, 0, 1);
        drive(3, 0, 1, 1, 0, 0, 0, 3, 0, 0, 0);
        drive(3, 0, 1, 1, 0, 0, 0, 3, 0, 0, 0);
        drive(3, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);        // rst mid-prescale
        for (int k = 0; k < 3; k++) drive(3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(3, 0, 1, 1, 0, 0, 0, 1, 0, 0, 1);
        drive(3, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0);
        drive(3, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0);
        drive(3, 0, 1, 1, 1, 7, 0, 7, 0, 0, 0);        // load clears prescaler
        for (int k = 0; k < 3; k++) drive(3, 0, 1, 1, 0, 0, 0, 7, 0, 0, 0);
        drive(3, 0, 1, 1, 0, 0, 0, 8, 0, 0, 1);

        @(negedge clk);
        rst = 1'b0; en = 1'b0; load = 1'b0; clr_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/param_updown_counter.md
PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits, legal range 1..32.
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1: terminal count, legal range 1..2**WIDTH-1; q spans 0..MAX_VAL.
REQ-003 Parameter PRESCALE, default 1: enabled cycles per count step, legal range 1..65535.
REQ-004 Parameter SATURATE, default 0: 0 = wrap at the limits, 1 = hold at the limits.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 en  input  1  count enable; when low, the prescaler and q hold.
REQ-008 up  input  1  direction: 1 = increment, 0 = decrement; sampled only in tick cycles.
REQ-009 load  input  1  synchronous load of load_val.
REQ-010 load_val  input  WIDTH  value to load.
REQ-011 clr_ovf  input  1  clears the sticky ovf flag.
REQ-012 q  output  WIDTH  registered count value.
REQ-013 tick  output  1  combinational step strobe: en AND prescaler == PRESCALE-1.
REQ-014 tc  output  1  registered one-cycle terminal-count pulse.
REQ-015 ovf  output  1  registered sticky overflow/underflow flag.

Function
REQ-016 Priority at each rising edge is rst > load > step > hold.
REQ-017 Prescaler counts 0..PRESCALE-1 on cycles with en=1 and wraps to 0 after PRESCALE-1; with PRESCALE=1, tick equals en.
REQ-018 q changes only on an edge where tick=1 or load=1.
REQ-019 Step up with q<MAX_VAL: q <= q+1; step down with q>0: q <= q-1.
REQ-020 Step up with q==MAX_VAL: q <= 0 if SATURATE=0, otherwise q holds MAX_VAL.
REQ-021 Step down with q==0: q <= MAX_VAL if SATURATE=0, otherwise q holds 0.
REQ-022 Each REQ-020/REQ-021 event sets tc=1 for exactly the following cycle and sets ovf=1; in saturate mode this repeats on every blocked step.
REQ-023 tc=0 in every cycle not directly following a REQ-022 event.
REQ-024 Load: q <= min(load_val, MAX_VAL); prescaler <= 0; tc <= 0; ovf is unchanged; a load in a tick cycle suppresses that step.
REQ-025 ovf stays 1 until clr_ovf=1; if a set event and clr_ovf coincide, set wins and ovf=1.
REQ-026 Changing up between ticks has no effect; only the value of up at the tick edge matters.
REQ-027 Internal arithmetic is WIDTH+1 bits or uses explicit compares; q never takes a value above MAX_VAL.

Reset
REQ-028 At an rst=1 edge: q=0, prescaler=0, tc=0, ovf=0, regardless of en, load, or clr_ovf.
REQ-029 rst asserted mid-prescale or mid-load discards pending state; counting resumes from q=0 with a full PRESCALE interval after rst deasserts.

Verification
REQ-030 WIDTH=3, default MAX_VAL, en=1, up=1, 9 cycles after reset -> q = 0,1,...,7,0; tc=1 only in the cycle after the 7->0 edge; ovf=1 afterwards.
REQ-031 WIDTH=4, MAX_VAL=9, up=0 from reset -> q = 9,8,...,0,9; tc pulses after the 0->9 step; clr_ovf=1 -> ovf=0 on the next cycle.
REQ-032 SATURATE=1, WIDTH=4, MAX_VAL=9, up=1, 12 steps -> q holds 9; tc pulses on every blocked step; ovf=1.
REQ-033 PRESCALE=4, en=1 continuously -> tick every 4th cycle; q increments once per 4 cycles; en low for 2 cycles delays the next tick by 2 cycles.
REQ-034 WIDTH=4, MAX_VAL=9: load=1, load_val=13 in a tick cycle -> q=9, no step, tc=0; next up step -> q=0, tc=1.
REQ-035 rst=1 together with load=1 and clr_ovf=0 while ovf=1 -> q=0, ovf=0, tc=0 at that edge.
